word_join: RTL
==============

// Module: word_join
// PURPOSE
//  Receive side of the byte-serial link fed by the word breaker: packs a stream of
//  WORD_IN_SIZE-bit bytes back into WORD_OUT_SIZE-bit words, MSB lane first.
//  Sits between the narrow link and the wide consumer.
//  Valid/ready handshake on both sides; one assembly register plus one output holding register.
//  Optional flush emits a partial word.
// PARAMETERS
//  WORD_IN_SIZE   8   width of each incoming byte/lane
//  WORD_OUT_SIZE  32  width of the assembled word; must be an integer multiple >=2 of WORD_IN_SIZE
//  (derived) LANES = WORD_OUT_SIZE/WORD_IN_SIZE; CW = $clog2(LANES)
// PORTS
//  clock      in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high reset
//  data_in    in   WORD_IN_SIZE   incoming byte
//  in_valid   in   1              data_in valid
//  in_ready   out  1              byte accepted when in_valid && in_ready
//  flush      in   1              close the current partial word (zero-pad the missing low lanes)
//  word_out   out  WORD_OUT_SIZE  assembled word, held stable while out_valid && !out_ready
//  out_bytes  out  CW+1           valid lanes in word_out (LANES for a full word, 1..LANES-1 after flush)
//  out_valid  out  1              word_out/out_bytes valid
//  out_ready  in   1              consumer takes word when out_valid && out_ready
//  fill_cnt   out  CW             lanes currently held in the assembly register
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, word_out=0, out_bytes=0, fill_cnt=0, asm_full=0.
//  Reset mid-word discards the partial word and any pending output word.
//  Lane order: the k-th accepted byte of a word (k=0..LANES-1) goes to
//   bits [WORD_OUT_SIZE-1-k*WORD_IN_SIZE -: WORD_IN_SIZE]. This matches the breaker's MSB-first emission.
//  in_ready = !asm_full (combinational from a register only; no in->out comb path).
//  Accept: assembly lane[fill_cnt] <= data_in; fill_cnt++ (CW-bit, wraps to 0 after LANES-1).
//  Word complete = accept with fill_cnt==LANES-1, OR flush with (fill_cnt>0 or accept this cycle).
//   A byte accepted in the flush cycle is included. Flush with fill_cnt==0 and no accept is ignored.
//   On flush, unfilled lanes are 0 and out_bytes = lanes filled including this cycle's byte.
//   Flush while asm_full is ignored.
//  Output slot free = !out_valid || out_ready.
//  Completed word, slot free:
//   - next cycle word_out = word, out_valid=1, out_bytes set, fill_cnt=0.
//   - Latency is 1 clock from last byte to out_valid.
//  Completed word, slot busy: word parks in the assembly register; asm_full=1, in_ready=0, fill_cnt=0.
//  Pending word (asm_full): when out_valid && out_ready, the pending word moves to the output
//   (out_valid stays 1) and asm_full=0. in_ready returns 1 the following cycle.
//  out_valid falls only on out_valid && out_ready with no word moving into the output that cycle.
//  Simultaneous drain and completion in the same cycle:
//   - the new word is loaded into the output with no bubble;
//   - full throughput is 1 byte/clock sustained.
//  Assertions:
//   - no accept while asm_full;
//   - word_out/out_bytes stable while out_valid && !out_ready;
//   - out_bytes != 0 whenever out_valid.
// STRUCTURE
//  Package word_link_pkg: default WORD_IN_SIZE/WORD_OUT_SIZE constants shared with the breaker;
//   lanes_f(out,in) function; byte-order note. The breaker and this block import it.
//  Sub-module word_hold_reg: output holding register.
//   Ports: load, data, bytes, out_ready -> word_out/out_bytes/out_valid.
//   Reusable as a 1-entry skid.
//  Top: assembly lanes, fill_cnt, asm_full, completion/flush logic, param check (initial $error).
// TESTING
//  1 Reset, then bytes AA,BB,CC,DD one per clock with out_ready=1
//    -> out_valid 1 clock after DD; word_out=AABBCCDD; out_bytes=4.
//  2 Eight bytes 01..08 back-to-back, out_ready=1
//    -> words 01020304 then 05060708 on consecutive words; in_ready never drops.
//  3 out_ready=0 and 8 bytes offered
//    -> word 1 held, word 2 parked, in_ready=0 after byte 8, fill_cnt=0.
//    Then out_ready=1 for 2 clocks -> 01020304 then 05060708, then in_ready=1.
//  4 Bytes 11,22 then flush with no byte -> word_out=11220000, out_bytes=2.
//    Flush with the 3rd byte 33 -> 11223300, out_bytes=3.
//    Flush with fill_cnt=0 -> no output.
//  5 Reset asserted after 2 bytes with an output pending -> out_valid=0, fill_cnt=0.
//    Next AA,BB,CC,DD -> AABBCCDD.
//  6 Loopback breaker->join with 1000 random words and random in_valid/out_ready -> identical word sequence.
//    Also WORD_OUT_SIZE=16 -> LANES=2.

Source files
------------

// File: rtl/word_link_pkg.sv
// Shared definitions for the byte-serial word link (word breaker / word joiner).
// Byte order on the link is MSB lane first: byte k of a word occupies bits [OUT-1-k*IN -: IN].
package word_link_pkg;

  localparam int WORD_IN_SIZE_DEF  = 8;
  localparam int WORD_OUT_SIZE_DEF = 32;

  function automatic int lanes_f(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry output holding register with valid/ready; usable as a 1-entry skid.
// The parent loads it only when the slot is free (empty, or being drained this cycle).
module word_hold_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [CNT_W-1:0]  bytes,
  input  logic              out_ready,
  output logic [DATA_W-1:0] word_out,
  output logic [CNT_W-1:0]  out_bytes,
  output logic              out_valid
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      word_out  <= '0;
      out_bytes <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      word_out  <= data;
      out_bytes <= bytes;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A load while the consumer is stalling would change a word it has not yet taken.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(out_valid && !out_ready && load))
        else $error("word_hold_reg: output changed while stalled");
      assert (!out_valid || out_bytes != '0)
        else $error("word_hold_reg: valid word with zero lanes");
    end
  end

endmodule

// File: rtl/word_join.sv
// Packs a stream of WORD_IN_SIZE-bit bytes into WORD_OUT_SIZE-bit words, MSB lane first,
// with flush for partial words, one parking slot in the assembly register and an output holding register.
module word_join
  import word_link_pkg::*;
#(
  parameter int WORD_IN_SIZE  = WORD_IN_SIZE_DEF,
  parameter int WORD_OUT_SIZE = WORD_OUT_SIZE_DEF,
  localparam int LANES = lanes_f(WORD_OUT_SIZE, WORD_IN_SIZE),
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WORD_IN_SIZE-1:0]  data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WORD_OUT_SIZE-1:0] word_out,
  output logic [CW:0]              out_bytes,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            fill_cnt
);

  if ((WORD_OUT_SIZE % WORD_IN_SIZE) != 0 || LANES < 2) begin : g_param_check
    $error("word_join: WORD_OUT_SIZE must be an integer multiple >= 2 of WORD_IN_SIZE");
  end

  logic [WORD_OUT_SIZE-1:0] asm_data;
  logic [WORD_OUT_SIZE-1:0] word;
  logic [WORD_OUT_SIZE-1:0] load_data;
  logic [CW:0]              asm_bytes;
  logic [CW:0]              count;
  logic [CW:0]              load_bytes;
  logic                     asm_full;
  logic                     accept;
  logic                     complete;
  logic                     slot_free;
  logic                     from_pending;
  logic                     load;

  assign in_ready     = !asm_full;
  assign accept       = in_valid && !asm_full;
  assign count        = {1'b0, fill_cnt} + {{CW{1'b0}}, accept};
  assign complete     = (accept && fill_cnt == CW'(LANES - 1))
                     || (flush && !asm_full && (fill_cnt != '0 || accept));
  assign slot_free    = !out_valid || out_ready;
  assign from_pending = asm_full && out_valid && out_ready;
  assign load         = from_pending || (complete && slot_free);
  assign load_data    = from_pending ? asm_data : word;
  assign load_bytes   = from_pending ? asm_bytes : count;

  // Lanes beyond the fill point are forced to zero, so a flushed word is zero-padded
  // and stale assembly contents never leak out.
  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(fill_cnt))
        word[WORD_OUT_SIZE-1-i*WORD_IN_SIZE -: WORD_IN_SIZE] =
          asm_data[WORD_OUT_SIZE-1-i*WORD_IN_SIZE -: WORD_IN_SIZE];
      else if (accept && i == int'(fill_cnt))
        word[WORD_OUT_SIZE-1-i*WORD_IN_SIZE -: WORD_IN_SIZE] = data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_cnt  <= '0;
      asm_full  <= 1'b0;
      asm_bytes <= '0;
    end else begin
      if (complete)
        fill_cnt <= '0;
      else if (accept)
        fill_cnt <= fill_cnt + CW'(1);
      if (from_pending) begin
        asm_full <= 1'b0;
      end else if (complete && !slot_free) begin
        asm_full  <= 1'b1;
        asm_bytes <= count;
      end
    end
  end

  // Assembly lanes hold either the partial word or, when asm_full, the parked word.
  always_ff @(posedge clock) begin
    if (accept || complete)
      asm_data <= word;
  end

  always_ff @(posedge clock) begin
    if (!reset)
      assert (!(asm_full && in_valid && in_ready))
        else $error("word_join: byte accepted while a word is parked");
  end

  word_hold_reg #(
    .DATA_W(WORD_OUT_SIZE),
    .CNT_W (CW + 1)
  ) u_hold (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .data     (load_data),
    .bytes    (load_bytes),
    .out_ready(out_ready),
    .word_out (word_out),
    .out_bytes(out_bytes),
    .out_valid(out_valid)
  );

endmodule
